// File: rtl/tcp_handshake_fsm.sv
// rtl/tcp_handshake_fsm.sv - single-connection TCP open/close control FSM
module tcp_handshake_fsm #(
    parameter int RETRY_CYCLES = 16,
    parameter int MAX_RETRIES  = 3,
    parameter int TW_CYCLES    = 32
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       Control,
    input  logic       app_close,
    input  logic       rx_valid,
    input  logic       rx_syn,
    input  logic       rx_ack,
    input  logic       rx_fin,
    input  logic       rx_rst,
    output logic       tx_valid,
    output logic       tx_syn,
    output logic       tx_ack,
    output logic       tx_fin,
    output logic [3:0] state,
    output logic       connected,
    output logic       error
);

    localparam int TMR_MAX = (RETRY_CYCLES > TW_CYCLES) ? RETRY_CYCLES : TW_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int RTY_W   = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    typedef enum logic [3:0] {
        CLOSED      = 4'd0,
        LISTEN      = 4'd1,
        SYN_SENT    = 4'd2,
        SYN_RCVD    = 4'd3,
        ESTABLISHED = 4'd4,
        FIN_WAIT_1  = 4'd5,
        FIN_WAIT_2  = 4'd6,
        CLOSING     = 4'd7,
        TIME_WAIT   = 4'd8,
        CLOSE_WAIT  = 4'd9,
        LAST_ACK    = 4'd10
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic               tx_valid_q, tx_valid_d;
    logic               tx_syn_q, tx_syn_d;
    logic               tx_ack_q, tx_ack_d;
    logic               tx_fin_q, tx_fin_d;
    logic               connected_q, connected_d;
    logic               error_q, error_d;

    logic seg_syn, seg_ack, seg_fin, seg_rst;
    assign seg_syn = rx_valid & rx_syn;
    assign seg_ack = rx_valid & rx_ack;
    assign seg_fin = rx_valid & rx_fin;
    assign seg_rst = rx_valid & rx_rst;

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        tx_syn_d = 1'b0;
        tx_ack_d = 1'b0;
        tx_fin_d = 1'b0;
        error_d  = 1'b0;
        timer_d  = (state_q == SYN_SENT || state_q == TIME_WAIT) ? timer_q + 1'b1 : '0;

        // RST aborts every synchronised or closing state; illegal codes are left to the default arm
        if (seg_rst && state_q >= SYN_SENT && state_q <= LAST_ACK) begin
            state_d = CLOSED;
            error_d = 1'b1;
        end else begin
            case (state_q)
                CLOSED: begin
                    if (Control) begin
                        state_d  = SYN_SENT;
                        tx_syn_d = 1'b1;
                    end else begin
                        state_d = LISTEN;
                    end
                end
                LISTEN: begin
                    if (seg_syn && !rx_ack) begin
                        state_d  = SYN_RCVD;
                        tx_syn_d = 1'b1;
                        tx_ack_d = 1'b1;
                    end else if (Control) begin
                        state_d  = SYN_SENT;
                        tx_syn_d = 1'b1;
                    end
                end
                SYN_SENT: begin
                    if (seg_syn && rx_ack) begin
                        state_d  = ESTABLISHED;
                        tx_ack_d = 1'b1;
                    end else if (seg_syn) begin
                        state_d  = SYN_RCVD;
                        tx_syn_d = 1'b1;
                        tx_ack_d = 1'b1;
                    end else if (timer_q == TMR_W'(RETRY_CYCLES - 1)) begin
                        if (retry_q == RTY_W'(MAX_RETRIES)) begin
                            state_d = CLOSED;
                            error_d = 1'b1;
                        end else begin
                            tx_syn_d = 1'b1;
                            timer_d  = '0;
                            retry_d  = retry_q + 1'b1;
                        end
                    end
                end
                SYN_RCVD: begin
                    if (seg_ack) state_d = ESTABLISHED;
                end
                ESTABLISHED: begin
                    if (seg_fin) begin
                        state_d  = CLOSE_WAIT;
                        tx_ack_d = 1'b1;
                    end else if (app_close) begin
                        state_d  = FIN_WAIT_1;
                        tx_fin_d = 1'b1;
                    end
                end
                FIN_WAIT_1: begin
                    if (seg_fin && rx_ack) begin
                        state_d  = TIME_WAIT;
                        tx_ack_d = 1'b1;
                    end else if (seg_ack) begin
                        state_d = FIN_WAIT_2;
                    end else if (seg_fin) begin
                        state_d  = CLOSING;
                        tx_ack_d = 1'b1;
                    end
                end
                FIN_WAIT_2: begin
                    if (seg_fin) begin
                        state_d  = TIME_WAIT;
                        tx_ack_d = 1'b1;
                    end
                end
                CLOSING: begin
                    if (seg_ack) state_d = TIME_WAIT;
                end
                TIME_WAIT: begin
                    if (timer_q == TMR_W'(TW_CYCLES - 1)) state_d = CLOSED;
                end
                CLOSE_WAIT: begin
                    if (app_close) begin
                        state_d  = LAST_ACK;
                        tx_fin_d = 1'b1;
                    end
                end
                LAST_ACK: begin
                    if (seg_ack) state_d = CLOSED;
                end
                default: state_d = CLOSED;
            endcase
        end

        if (state_d != state_q) timer_d = '0;
        if (state_d != SYN_SENT) retry_d = '0;
        tx_valid_d  = tx_syn_d | tx_ack_d | tx_fin_d;
        connected_d = (state_d == ESTABLISHED);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= CLOSED;
            timer_q     <= '0;
            retry_q     <= '0;
            tx_valid_q  <= 1'b0;
            tx_syn_q    <= 1'b0;
            tx_ack_q    <= 1'b0;
            tx_fin_q    <= 1'b0;
            connected_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            tx_valid_q  <= tx_valid_d;
            tx_syn_q    <= tx_syn_d;
            tx_ack_q    <= tx_ack_d;
            tx_fin_q    <= tx_fin_d;
            connected_q <= connected_d;
            error_q     <= error_d;
        end
    end

    assign state     = state_q;
    assign tx_valid  = tx_valid_q;
    assign tx_syn    = tx_syn_q;
    assign tx_ack    = tx_ack_q;
    assign tx_fin    = tx_fin_q;
    assign connected = connected_q;
    assign error     = error_q;

endmodule

// File: tb/tb_tcp_handshake_fsm.sv
// tb/tb_tcp_handshake_fsm.sv - directed plus random check of tcp_handshake_fsm against a connection model
module tb_tcp_handshake_fsm;

    localparam int RETRY = 16;
    localparam int MAXR  = 3;
    localparam int TW    = 32;

    logic       clock = 1'b0;
    logic       rst = 1'b1;
    logic       Control = 1'b0;
    logic       app_close = 1'b0;
    logic       rx_valid = 1'b0;
    logic       rx_syn = 1'b0;
    logic       rx_ack = 1'b0;
    logic       rx_fin = 1'b0;
    logic       rx_rst = 1'b0;
    logic       tx_valid, tx_syn, tx_ack, tx_fin, connected, error;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    tcp_handshake_fsm #(.RETRY_CYCLES(RETRY), .MAX_RETRIES(MAXR), .TW_CYCLES(TW)) dut (
        .clock(clock), .rst(rst), .Control(Control), .app_close(app_close),
        .rx_valid(rx_valid), .rx_syn(rx_syn), .rx_ack(rx_ack), .rx_fin(rx_fin), .rx_rst(rx_rst),
        .tx_valid(tx_valid), .tx_syn(tx_syn), .tx_ack(tx_ack), .tx_fin(tx_fin),
        .state(state), .connected(connected), .error(error)
    );

    always #5 clock = ~clock;

    // Connection model: m_tick counts cycles since entering the state or since the last SYN went out
    int m_state = 0;
    int m_tick = 0;
    int m_sent_retries = 0;
    bit e_txv = 0, e_syn = 0, e_ack = 0, e_fin = 0, e_conn = 0, e_err = 0;

    always @(posedge clock) begin : model
        int  ns;
        bit  s, a, f, er, resend;
        if (rst) begin
            m_state = 0; m_tick = 0; m_sent_retries = 0;
            {e_txv, e_syn, e_ack, e_fin, e_conn, e_err} = '0;
        end else begin
            ns = m_state; s = 0; a = 0; f = 0; er = 0; resend = 0;
            if (rx_valid && rx_rst && m_state >= 2 && m_state <= 10) begin
                ns = 0; er = 1;
            end else begin
                case (m_state)
                    0: if (Control) begin ns = 2; s = 1; end else ns = 1;
                    1: if (rx_valid && rx_syn && !rx_ack) begin ns = 3; s = 1; a = 1; end
                       else if (Control) begin ns = 2; s = 1; end
                    2: if (rx_valid && rx_syn) begin
                           if (rx_ack) begin ns = 4; a = 1; end
                           else begin ns = 3; s = 1; a = 1; end
                       end else if (m_tick + 1 == RETRY) begin
                           if (m_sent_retries == MAXR) begin ns = 0; er = 1; end
                           else begin s = 1; resend = 1; m_sent_retries++; end
                       end
                    3: if (rx_valid && rx_ack) ns = 4;
                    4: if (rx_valid && rx_fin) begin ns = 9; a = 1; end
                       else if (app_close) begin ns = 5; f = 1; end
                    5: if (rx_valid && rx_fin && rx_ack) begin ns = 8; a = 1; end
                       else if (rx_valid && rx_ack) ns = 6;
                       else if (rx_valid && rx_fin) begin ns = 7; a = 1; end
                    6: if (rx_valid && rx_fin) begin ns = 8; a = 1; end
                    7: if (rx_valid && rx_ack) ns = 8;
                    8: if (m_tick + 1 == TW) ns = 0;
                    9: if (app_close) begin ns = 10; f = 1; end
                    10: if (rx_valid && rx_ack) ns = 0;
                    default: ns = 0;
                endcase
            end
            if (ns != m_state || resend) m_tick = 0; else m_tick++;
            if (ns != 2) m_sent_retries = 0;
            m_state = ns;
            e_syn = s; e_ack = a; e_fin = f; e_txv = s | a | f;
            e_conn = (ns == 4); e_err = er;
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin : compare
        chk("model.state", int'(state), m_state);
        chk("model.tx_valid", int'(tx_valid), int'(e_txv));
        chk("model.tx_syn", int'(tx_syn), int'(e_syn));
        chk("model.tx_ack", int'(tx_ack), int'(e_ack));
        chk("model.tx_fin", int'(tx_fin), int'(e_fin));
        chk("model.connected", int'(connected), int'(e_conn));
        chk("model.error", int'(error), int'(e_err));
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic seg(bit v, bit s, bit a, bit f, bit r);
        rx_valid = v; rx_syn = s; rx_ack = a; rx_fin = f; rx_rst = r;
    endtask

    task automatic lit(string name, int st, bit txv, bit s, bit a, bit f, bit conn, bit err);
        chk({name, ".state"}, int'(state), st);
        chk({name, ".tx_valid"}, int'(tx_valid), int'(txv));
        chk({name, ".tx_syn"}, int'(tx_syn), int'(s));
        chk({name, ".tx_ack"}, int'(tx_ack), int'(a));
        chk({name, ".tx_fin"}, int'(tx_fin), int'(f));
        chk({name, ".connected"}, int'(connected), int'(conn));
        chk({name, ".error"}, int'(error), int'(err));
    endtask

    initial begin
        // reset and idle
        tick();
        lit("reset", 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        tick();
        lit("idle_listen", 1, 0, 0, 0, 0, 0, 0);

        // active open
        Control = 1'b1;
        tick();
        lit("aopen_syn", 2, 1, 1, 0, 0, 0, 0);
        tick();
        seg(1, 1, 1, 0, 0);
        tick();
        seg(0, 0, 0, 0, 0);
        lit("aopen_est", 4, 1, 0, 1, 0, 1, 0);

        // RST abort from ESTABLISHED
        seg(1, 0, 0, 0, 1);
        tick();
        seg(0, 0, 0, 0, 0);
        Control = 1'b0;
        lit("rst_abort", 0, 0, 0, 0, 0, 0, 1);
        tick();
        lit("back_listen", 1, 0, 0, 0, 0, 0, 0);

        // passive open
        seg(1, 1, 0, 0, 0);
        tick();
        lit("popen_synack", 3, 1, 1, 1, 0, 0, 0);
        seg(1, 0, 1, 0, 0);
        tick();
        seg(0, 0, 0, 0, 0);
        lit("popen_est", 4, 0, 0, 0, 0, 1, 0);

        // active close through TIME_WAIT
        app_close = 1'b1;
        tick();
        app_close = 1'b0;
        lit("aclose_fin", 5, 1, 0, 0, 1, 0, 0);
        seg(1, 0, 1, 0, 0);
        tick();
        lit("aclose_fw2", 6, 0, 0, 0, 0, 0, 0);
        seg(1, 0, 0, 1, 0);
        tick();
        seg(0, 0, 0, 0, 0);
        lit("aclose_tw", 8, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < TW - 1; i++) tick();
        lit("tw_last", 8, 0, 0, 0, 0, 0, 0);
        tick();
        lit("tw_done", 0, 0, 0, 0, 0, 0, 0);
        tick();

        // passive close with simultaneous app_close
        seg(1, 1, 0, 0, 0);
        tick();
        seg(1, 0, 1, 0, 0);
        tick();
        seg(1, 0, 0, 1, 0);
        app_close = 1'b1;
        tick();
        seg(0, 0, 0, 0, 0);
        lit("pclose_cw", 9, 1, 0, 1, 0, 0, 0);
        tick();
        app_close = 1'b0;
        lit("pclose_lastack", 10, 1, 0, 0, 1, 0, 0);
        seg(1, 0, 1, 0, 0);
        tick();
        seg(0, 0, 0, 0, 0);
        lit("pclose_closed", 0, 0, 0, 0, 0, 0, 0);

        // retry exhaustion
        Control = 1'b1;
        tick();
        lit("retry_t0", 2, 1, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 4 * RETRY; i++) begin
            tick();
            if (i == 4 * RETRY) begin
                Control = 1'b0;
                lit("retry_giveup", 0, 0, 0, 0, 0, 0, 1);
            end else if (i % RETRY == 0) begin
                chk("retry_resend.state", int'(state), 2);
                chk("retry_resend.tx_syn", int'(tx_syn), 1);
            end else begin
                chk("retry_wait.tx_valid", int'(tx_valid), 0);
            end
        end
        tick();

        // randomized traffic
        for (int i = 0; i < 5000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 9) == 0) Control = $urandom_range(0, 1);
            app_close = ($urandom_range(0, 4) == 0);
            rx_valid  = ($urandom_range(0, 9) < 4);
            rx_syn    = $urandom_range(0, 1);
            rx_ack    = $urandom_range(0, 1);
            rx_fin    = $urandom_range(0, 1);
            rx_rst    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) seg(0, 0, 0, 0, 0);
            tick();
        end
        rst = 1'b0;
        seg(0, 0, 0, 0, 0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
